// File: rtl/mt_host_driver.sv
// mt_host_driver: drives a paged target through a clocked page/input load
// sequence and returns the sampled target output.
// Optional feature: define MT_HOST_DRIVER_PAGE_CACHE_EN to skip the page-load
// phase when the requested page matches the last page that was loaded.
module mt_host_driver #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_page,
    input  logic [5:0] req_in,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [7:0] tgt_io_in,
    input  logic [7:0] tgt_io_out
);

    localparam int unsigned CW     = 8;
    localparam int unsigned SW     = 6;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        PAGE_LO,
        PAGE_HI,
        IN_LO,
        IN_HI,
        SETTLE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [SW-1:0]   page_q;
    logic [SW-1:0]   in_q;
    logic [SW-1:0]   page_sel;
    logic [SW-1:0]   in_sel;
    logic [7:0]      io_nx;
    logic            accept;
    logic            cnt_zero;
    logic            hit;

`ifdef MT_HOST_DRIVER_PAGE_CACHE_EN
    logic [SW-1:0]   last_page;
    logic            cache_valid;

    // Page-cache hit: same page already resident in the target
    assign hit = cache_valid && (req_page == last_page);
`else
    assign hit = 1'b0;
`endif

    // Handshake and selection of the values for the cycle after accept
    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign cnt_zero  = (cnt == '0);
    assign page_sel  = accept ? req_page : page_q;
    assign in_sel    = accept ? req_in   : in_q;

    // Next-state, dwell counter and next pin value
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        io_nx    = tgt_io_in;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = hit ? IN_LO : PAGE_LO;
                    cnt_nx   = RELOAD;
                end
            end
            PAGE_LO, PAGE_HI, IN_LO, IN_HI: begin
                if (cnt_zero) begin
                    state_nx = state_t'(state + 3'd1);
                    cnt_nx   = RELOAD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Pin pattern is a function of the state about to be occupied
        unique case (state_nx)
            IDLE:    io_nx = {tgt_io_in[7:2], 2'b00};
            PAGE_LO: io_nx = {page_sel, 2'b10};
            PAGE_HI: io_nx = {page_sel, 2'b11};
            IN_LO:   io_nx = {in_sel, 2'b00};
            IN_HI:   io_nx = {in_sel, 2'b01};
            SETTLE:  io_nx = {in_sel, 2'b00};
            default: io_nx = tgt_io_in;
        endcase
    end

    // State, pins, response and request capture registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt_io_in <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            page_q    <= '0;
            in_q      <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tgt_io_in <= io_nx;
            rsp_valid <= (state_nx == DONE);
            if (state == SETTLE && cnt_zero) begin
                rsp_data <= tgt_io_out;
            end
            if (accept) begin
                page_q <= req_page;
                in_q   <= req_in;
            end
        end
    end

`ifdef MT_HOST_DRIVER_PAGE_CACHE_EN
    // Record the page once its load sequence completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_page   <= '0;
            cache_valid <= 1'b0;
        end else if (state == PAGE_HI && cnt_zero) begin
            last_page   <= page_q;
            cache_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mt_host_driver.sv
// Self-checking bench for mt_host_driver with DIV=2.
// Exercises cache behaviour when MT_HOST_DRIVER_PAGE_CACHE_EN is defined.
module tb_mt_host_driver;

    localparam int unsigned DIV = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_page;
    logic [5:0] req_in;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [7:0] tgt_io_in;
    logic [7:0] tgt_io_out;

    int n_checks;
    int n_fail;

    mt_host_driver #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_page   (req_page),
        .req_in     (req_in),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .tgt_io_in  (tgt_io_in),
        .tgt_io_out (tgt_io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: request, tied target output, expected pin value per phase
    // (PAGE_LO, PAGE_HI, IN_LO, IN_HI, SETTLE) and expected response.
    typedef struct packed {
        logic [5:0]      page;
        logic [5:0]      in;
        logic [7:0]      tout;
        logic [4:0][7:0] exp_io;
        logic [7:0]      exp_rsp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply a reset for two cycles and release it at a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_io", tgt_io_in, 8'h00);
        check("rst_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_ready_low", {7'd0, req_ready}, 8'h00);
        rst_n = 1'b1;
        #1;
        check("rst_ready_high", {7'd0, req_ready}, 8'h01);
    endtask

    // Full request with per-cycle pin checks; noise on inputs while busy
    task automatic run_vec(input vec_t v);
        req_page   = v.page;
        req_in     = v.in;
        tgt_io_out = v.tout;
        req_valid  = 1'b1;
        #1;
        check("accept_ready", {7'd0, req_ready}, 8'h01);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 5 * DIV; k++) begin
            req_valid = (k % 2 == 1) && (k < 5 * DIV - 1);
            req_page  = ~v.page;
            req_in    = v.in ^ 6'h2D;
            @(negedge clk);
            check("phase_io", tgt_io_in, v.exp_io[(k - 1) / DIV]);
            check("busy_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("done_rsp_valid", {7'd0, rsp_valid}, 8'h01);
        check("done_rsp_data", rsp_data, v.exp_rsp);
        check("done_ready", {7'd0, req_ready}, 8'h00);
        @(negedge clk);
        check("idle_ready", {7'd0, req_ready}, 8'h01);
        check("idle_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        check("idle_io", tgt_io_in, {v.in, 2'b00});
        check("idle_rsp_hold", rsp_data, v.exp_rsp);
    endtask

    // Issue one request; report cycles to rsp_valid and whether page_mode was seen
    task automatic measure(input logic [5:0] page, input logic [5:0] in,
                           output int lat, output bit pm_seen);
        lat     = -1;
        pm_seen = 1'b0;
        @(negedge clk);
        req_page  = page;
        req_in    = in;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (tgt_io_in[1]) pm_seen = 1'b1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    int  acc_cyc [2];
    int  n_acc;
    int  n_rsp;
    int  lat;
    bit  pm;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_page   = '0;
        req_in     = '0;
        tgt_io_out = 8'h00;

        // page_mode=1 during page phases, target clock low then high
        vecs[0] = '{page: 6'h05, in: 6'h2A, tout: 8'h9C,
                    exp_io: {8'hA8, 8'hA9, 8'hA8, 8'h17, 8'h16}, exp_rsp: 8'h9C};
        vecs[1] = '{page: 6'h3F, in: 6'h00, tout: 8'h5A,
                    exp_io: {8'h00, 8'h01, 8'h00, 8'hFF, 8'hFE}, exp_rsp: 8'h5A};
        vecs[2] = '{page: 6'h00, in: 6'h15, tout: 8'hA5,
                    exp_io: {8'h54, 8'h55, 8'h54, 8'h03, 8'h02}, exp_rsp: 8'hA5};
        vecs[3] = '{page: 6'h2A, in: 6'h3F, tout: 8'hFF,
                    exp_io: {8'hFC, 8'hFD, 8'hFC, 8'hAB, 8'hAA}, exp_rsp: 8'hFF};

        do_reset();

`ifndef MT_HOST_DRIVER_PAGE_CACHE_EN
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end
`else
        run_vec(vecs[0]);
`endif

        // Reset in the middle of a request aborts it cleanly
        do_reset();
        req_page   = 6'h12;
        req_in     = 6'h34;
        tgt_io_out = 8'h77;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_io", tgt_io_in, 8'h00);
        check("abort_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        check("abort_ready_low", {7'd0, req_ready}, 8'h00);
        rst_n = 1'b1;
        #1;
        check("abort_ready_high", {7'd0, req_ready}, 8'h01);
        n_rsp = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        check("abort_no_rsp", 8'(n_rsp), 8'd0);
        check("abort_rsp_data", rsp_data, 8'h00);

        // Back-to-back: req_valid held high across two requests
        do_reset();
        tgt_io_out = 8'h3C;
        req_page   = 6'h01;
        req_in     = 6'h02;
        req_valid  = 1'b1;
        n_acc      = 0;
        n_rsp      = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (rsp_valid) n_rsp++;
            if (req_valid && req_ready) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (n_acc == 1) begin
                req_page = 6'h0B;
                req_in   = 6'h1C;
            end else if (n_acc == 2) begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_accepts", 8'(n_acc), 8'd2);
        check("b2b_gap", 8'(acc_cyc[1] - acc_cyc[0]), 8'(5 * DIV + 2));
        check("b2b_rsp_count", 8'(n_rsp), 8'd2);
        check("b2b_io", tgt_io_in, {6'h1C, 2'b00});

        // Latency: repeated page, then a different page
        do_reset();
        tgt_io_out = 8'h4E;
        measure(6'h05, 6'h11, lat, pm);
        check("lat_first", 8'(lat), 8'(5 * DIV + 1));
        measure(6'h05, 6'h22, lat, pm);
`ifdef MT_HOST_DRIVER_PAGE_CACHE_EN
        check("lat_repeat", 8'(lat), 8'(3 * DIV + 1));
        check("repeat_no_page_mode", {7'd0, pm}, 8'h00);
`else
        check("lat_repeat", 8'(lat), 8'(5 * DIV + 1));
        check("repeat_page_mode", {7'd0, pm}, 8'h01);
`endif
        measure(6'h06, 6'h33, lat, pm);
        check("lat_new_page", 8'(lat), 8'(5 * DIV + 1));
        check("new_page_mode", {7'd0, pm}, 8'h01);
        check("lat_rsp_data", rsp_data, 8'h4E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
